// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, framing FSM states and
// default buffer geometry for the router input channel.
package noc_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 4;

   typedef enum logic [1:0] {
      FLIT_SINGLE = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_BODY   = 2'b10,
      FLIT_TAIL   = 2'b11
   } flit_type_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/flit_fifo_mem.sv
// Flit storage: DEPTH entries of {type, payload}. Synchronous write,
// asynchronous read so the FIFO head is visible in the same cycle.
module flit_fifo_mem #(
   parameter int ENTRY_W = 10,
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = 2
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [ADDR_W-1:0]  i_waddr,
   input  logic [ENTRY_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0]  i_raddr,
   output logic [ENTRY_W-1:0] o_rdata
);

   logic [ENTRY_W-1:0] r_mem [DEPTH];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Show-ahead read of the entry at the read pointer.
   always_comb begin
      o_rdata = r_mem[i_raddr];
   end

endmodule

// File: rtl/input_channel_buffer.sv
// Router input-channel flit FIFO: stores accepted flits, enforces
// head/body/tail framing, and returns credits to the upstream sender.
module input_channel_buffer
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int ADDR_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [1:0]            in_type,
   input  logic [DATA_WIDTH-1:0] in_flit,
   output logic                  out_valid,
   output logic [1:0]            out_type,
   output logic [DATA_WIDTH-1:0] out_flit,
   input  logic                  out_ready,
   output logic [1:0]            credit_out,
   output logic [ADDR_W:0]       count,
   output logic                  proto_err,
   output logic                  overflow_err
);

   localparam int CNT_W   = ADDR_W + 1;
   localparam int ENTRY_W = DATA_WIDTH + 2;

   fsm_state_e         r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [1:0]         r_credit;
   logic               r_proto_err, r_overflow_err;

   logic               w_legal, w_full, w_pop, w_block;
   logic               w_push, w_ovf, w_fdrop, w_fcredit;
   logic [ENTRY_W-1:0] w_rdata;

   // Framing legality, push/drop classification and next FSM state.
   // A full buffer with no pop rejects everything (no credit), and only
   // an actually stored flit may advance the framing FSM.
   always_comb begin
      w_legal     = 1'b0;
      w_state_nxt = r_state;
      w_full      = (r_count == CNT_W'(DEPTH));
      w_pop       = (r_count != '0) && out_ready;
      w_block     = w_full && !w_pop;
      case (r_state)
         ST_IDLE:   w_legal = (in_type == FLIT_SINGLE) || (in_type == FLIT_HEAD);
         ST_IN_PKT: w_legal = (in_type == FLIT_BODY)   || (in_type == FLIT_TAIL);
         default:   w_legal = 1'b0;
      endcase
      w_push    = in_valid && w_legal && !w_block;
      w_ovf     = in_valid && w_block;
      w_fdrop   = in_valid && !w_legal;
      w_fcredit = w_fdrop && !w_block;
      if (w_push) begin
         if ((r_state == ST_IDLE) && (in_type == FLIT_HEAD))
            w_state_nxt = ST_IN_PKT;
         else if ((r_state == ST_IN_PKT) && (in_type == FLIT_TAIL))
            w_state_nxt = ST_IDLE;
      end
   end

   // Framing FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Read/write pointers; DEPTH is a power of two so they wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
   end

   // Occupancy: full/empty come from this, not from pointer equality.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // One credit per freed slot: a pop, or a framing drop that consumed
   // an upstream credit without occupying a buffer entry.
   always_ff @(posedge clk) begin
      if (!rst_n) r_credit <= '0;
      else        r_credit <= 2'(w_pop) + 2'(w_fcredit);
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_proto_err    <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         if (w_fdrop) r_proto_err    <= 1'b1;
         if (w_ovf)   r_overflow_err <= 1'b1;
      end
   end

   flit_fifo_mem #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata ({in_type, in_flit}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign out_valid    = (r_count != '0);
   assign out_type     = w_rdata[ENTRY_W-1 -: 2];
   assign out_flit     = w_rdata[DATA_WIDTH-1:0];
   assign credit_out   = r_credit;
   assign count        = r_count;
   assign proto_err    = r_proto_err;
   assign overflow_err = r_overflow_err;

endmodule

// File: tb/tb_input_channel_buffer.sv
// Directed bench for input_channel_buffer. Stored flits are queued on a
// scoreboard as they are sent; a negedge monitor checks every pop.
module tb_input_channel_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] in_type;
   logic [7:0] in_flit;
   logic       out_valid;
   logic [1:0] out_type;
   logic [7:0] out_flit;
   logic       out_ready;
   logic [1:0] credit_out;
   logic [2:0] count;
   logic       proto_err;
   logic       overflow_err;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [1:0] t;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   input_channel_buffer #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_W(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_type      (in_type),
      .in_flit      (in_flit),
      .out_valid    (out_valid),
      .out_type     (out_type),
      .out_flit     (out_flit),
      .out_ready    (out_ready),
      .credit_out   (credit_out),
      .count        (count),
      .proto_err    (proto_err),
      .overflow_err (overflow_err)
   );

   // Monitor: each accepted pop must match the oldest expected flit.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected got type=%0d flit=%h, scoreboard empty", out_type, out_flit);
         end else begin
            e = sb.pop_front();
            if (out_type !== e.t || out_flit !== e.d) begin
               n_err++;
               $display("FAIL pop_data got type=%0d flit=%h, exp type=%0d flit=%h",
                        out_type, out_flit, e.t, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs; returns 1 time unit after the edge.
   task automatic drive(input logic v, input logic [1:0] t, input logic [7:0] d, input logic rdy);
      in_valid  = v;
      in_type   = t;
      in_flit   = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_flit(input logic [1:0] t, input logic [7:0] d);
      sb.push_back('{t: t, d: d});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      sb.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_type = 2'b00; in_flit = 8'h00; out_ready = 1'b0;

      // 1: packet stored then drained in order
      do_reset();
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_credit", credit_out, 0);
      chk("rst_proto", proto_err, 0);
      chk("rst_ovf", overflow_err, 0);
      expect_flit(2'b01, 8'ha1); drive(1'b1, 2'b01, 8'ha1, 1'b0);
      chk("t1_latency_valid", out_valid, 1);
      expect_flit(2'b10, 8'hb2); drive(1'b1, 2'b10, 8'hb2, 1'b0);
      expect_flit(2'b11, 8'hc3); drive(1'b1, 2'b11, 8'hc3, 1'b0);
      chk("t1_count3", count, 3);
      chk("t1_head_flit", out_flit, 8'ha1);
      chk("t1_head_type", out_type, 1);
      chk("t1_no_credit", credit_out, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'b00, 8'h00, 1'b1);
         chk("t1_credit_pop", credit_out, 1);
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      chk("t1_count0", count, 0);
      chk("t1_credit_idle", credit_out, 0);

      // 2: overflow on a 5th flit with no pop
      for (int i = 1; i <= 4; i++) begin
         expect_flit(2'b00, 8'(i));
         drive(1'b1, 2'b00, 8'(i), 1'b0);
      end
      drive(1'b1, 2'b00, 8'h05, 1'b0);
      chk("t2_ovf", overflow_err, 1);
      chk("t2_count4", count, 4);
      chk("t2_head", out_flit, 8'h01);
      chk("t2_credit0", credit_out, 0);
      chk("t2_no_proto", proto_err, 0);

      // 3: push into a full FIFO with a same-cycle pop
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         expect_flit(2'b00, 8'(i));
         drive(1'b1, 2'b00, 8'(i), 1'b0);
      end
      chk("t3_full", count, 4);
      expect_flit(2'b00, 8'h55);
      drive(1'b1, 2'b00, 8'h55, 1'b1);
      chk("t3_count4", count, 4);
      chk("t3_no_ovf", overflow_err, 0);
      chk("t3_credit1", credit_out, 1);
      for (int i = 0; i < 4; i++) drive(1'b0, 2'b00, 8'h00, 1'b1);
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      chk("t3_drained", count, 0);
      chk("t3_sb_empty", sb.size(), 0);

      // 4: framing drops
      drive(1'b1, 2'b10, 8'h10, 1'b0);
      chk("t4_proto", proto_err, 1);
      chk("t4_credit_drop", credit_out, 1);
      chk("t4_count0", count, 0);
      chk("t4_no_valid", out_valid, 0);
      expect_flit(2'b01, 8'h20);
      drive(1'b1, 2'b01, 8'h20, 1'b0);
      chk("t4_head_credit0", credit_out, 0);
      drive(1'b1, 2'b01, 8'h21, 1'b0);
      chk("t4_head2_credit", credit_out, 1);
      chk("t4_head2_count", count, 1);

      // 5: pop and framing drop together
      drive(1'b1, 2'b00, 8'h30, 1'b1);
      chk("t5_credit2", credit_out, 2);
      chk("t5_count0", count, 0);
      drive(1'b0, 2'b00, 8'h00, 1'b0);

      // 6: reset mid-packet
      expect_flit(2'b10, 8'h40); drive(1'b1, 2'b10, 8'h40, 1'b0);
      expect_flit(2'b10, 8'h41); drive(1'b1, 2'b10, 8'h41, 1'b0);
      chk("t6_count2", count, 2);
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      sb.delete();
      chk("t6_rst_count", count, 0);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_proto", proto_err, 0);
      chk("t6_rst_ovf", overflow_err, 0);
      rst_n = 1'b1;
      drive(1'b1, 2'b10, 8'h50, 1'b0);
      chk("t6_body_proto", proto_err, 1);
      chk("t6_body_count", count, 0);
      chk("t6_body_credit", credit_out, 1);
      drive(1'b0, 2'b00, 8'h00, 1'b0);
      chk("end_sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
